// File: rtl/uart_line_assembler.sv
// Line-buffered echo: collects received bytes until TERM or a full buffer, then replays the line plus CR LF.
// Optional build macro UART_LINE_UPCASE_EN upper-cases 'a'..'z' while the stored line is replayed.
module uart_line_assembler #(
  parameter int                 WIDTH   = 8,
  parameter int                 MAX_LEN = 32,
  parameter logic [WIDTH-1:0]   TERM    = 8'h0D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_new_data,
  input  logic             tx_full,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_strobe,
  output logic             busy,
  output logic             overflow
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int PW = AW + 1;
  localparam logic [WIDTH-1:0] CR_BYTE = WIDTH'(8'h0D);
  localparam logic [WIDTH-1:0] LF_BYTE = WIDTH'(8'h0A);

  typedef enum logic [1:0] {
    COLLECT,
    FLUSH,
    SEND_CR,
    SEND_LF
  } state_t;

  state_t           state, next_state;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [WIDTH-1:0] line_buf [MAX_LEN];
  logic             can_send;
  logic             store_byte;
  logic             flush_write;

`ifdef UART_LINE_UPCASE_EN
  function automatic logic [WIDTH-1:0] replay_byte(input logic [WIDTH-1:0] b);
    if (b >= WIDTH'(8'h61) && b <= WIDTH'(8'h7A))
      return b - WIDTH'(8'h20);
    return b;
  endfunction
`else
  function automatic logic [WIDTH-1:0] replay_byte(input logic [WIDTH-1:0] b);
    return b;
  endfunction
`endif

  // A write is only allowed when the FIFO has room and no strobe went out last cycle,
  // so the full flag always gets one cycle to reflect the previous write.
  assign can_send = !tx_full && !tx_strobe;

  always_comb begin
    next_state  = state;
    store_byte  = 1'b0;
    flush_write = 1'b0;
    case (state)
      COLLECT: begin
        if (rx_new_data) begin
          if (rx_data == TERM) begin
            next_state = FLUSH;
          end else begin
            store_byte = 1'b1;
            if (wr_ptr == PW'(MAX_LEN - 1))
              next_state = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (rd_ptr == wr_ptr)
          next_state = SEND_CR;
        else if (can_send)
          flush_write = 1'b1;
      end
      SEND_CR: begin
        if (can_send)
          next_state = SEND_LF;
      end
      SEND_LF: begin
        if (can_send)
          next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (store_byte)
      line_buf[wr_ptr[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= COLLECT;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tx_data   <= '0;
      tx_strobe <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= next_state;
      busy      <= (next_state != COLLECT);
      overflow  <= rx_new_data && (state != COLLECT);
      tx_strobe <= 1'b0;
      if (store_byte)
        wr_ptr <= wr_ptr + 1'b1;
      if (flush_write) begin
        tx_strobe <= 1'b1;
        tx_data   <= replay_byte(line_buf[rd_ptr[AW-1:0]]);
        rd_ptr    <= rd_ptr + 1'b1;
      end
      if (state == SEND_CR && can_send) begin
        tx_strobe <= 1'b1;
        tx_data   <= CR_BYTE;
      end
      if (state == SEND_LF && can_send) begin
        tx_strobe <= 1'b1;
        tx_data   <= LF_BYTE;
        wr_ptr    <= '0;
        rd_ptr    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_line_assembler.sv
// Scoreboard bench for uart_line_assembler: expected tx bytes are queued as rx bytes are driven.
module tb_uart_line_assembler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_new_data = 1'b0;
  logic       tx_full = 1'b0;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic       busy;
  logic       overflow;

  int         vectors = 0;
  int         miscompares = 0;
  int         strobe_count = 0;
  int         line_len = 0;
  logic       prev_strobe = 1'b0;
  logic [7:0] exp_q [$];

  uart_line_assembler #(.WIDTH(8), .MAX_LEN(32), .TERM(8'h0D)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_new_data(rx_new_data),
    .tx_full(tx_full), .tx_data(tx_data), .tx_strobe(tx_strobe),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] b);
`ifdef UART_LINE_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A)
      return b - 8'h20;
`endif
    return b;
  endfunction

  // Drive one rx byte; unless it is expected to be dropped, queue what the line should replay.
  task automatic applyStimulus(input logic [7:0] b, input bit drop = 0);
    @(posedge clk); #1;
    rx_data = b;
    rx_new_data = 1'b1;
    if (!drop) begin
      if (b == 8'h0D) begin
        exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
        line_len = 0;
      end else begin
        exp_q.push_back(exp_byte(b));
        line_len++;
        if (line_len == 32) begin
          exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
          line_len = 0;
        end
      end
    end
    @(posedge clk); #1;
    rx_new_data = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy || tx_strobe) && n < 2000);
    if (n >= 2000)
      checkOutput("idle_timeout", 0, 1);
  endtask

  // Every strobe is popped against the scoreboard; LF marks the end of a line and busy must already be low.
  always @(negedge clk) begin
    if (tx_strobe) begin
      strobe_count++;
      checkOutput("strobe_spacing", prev_strobe, 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_strobe", {24'h0, tx_data}, 32'h100);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checkOutput("tx_data", tx_data, e);
        checkOutput("busy_during_tx", busy, (e == 8'h0A) ? 0 : 1);
      end
    end
    prev_strobe = tx_strobe;
  end

  initial begin
    int s0;
    int n;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_tx_data", tx_data, 0);
    checkOutput("rst_tx_strobe", tx_strobe, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overflow", overflow, 0);

    // "hi" CR
    applyStimulus(8'h68);
    applyStimulus(8'h69);
    applyStimulus(8'h0D);
    @(negedge clk);
    checkOutput("busy_after_term", busy, 1);
    wait_idle();

    // Bare CR gives exactly CR LF
    s0 = strobe_count;
    applyStimulus(8'h0D);
    wait_idle();
    checkOutput("bare_cr_strobes", strobe_count - s0, 2);

    // 32 bytes force a line break; next byte starts a fresh line at index 0
    s0 = strobe_count;
    for (int i = 0; i < 32; i++)
      applyStimulus(8'h30 + 8'(i));
    @(negedge clk);
    checkOutput("busy_after_full", busy, 1);
    wait_idle();
    checkOutput("full_line_strobes", strobe_count - s0, 34);
    applyStimulus(8'h5A);
    applyStimulus(8'h0D);
    wait_idle();

    // tx_full held for 100 cycles after FLUSH entry
    applyStimulus(8'h61);
    applyStimulus(8'h62);
    applyStimulus(8'h63);
    tx_full = 1'b1;
    s0 = strobe_count;
    applyStimulus(8'h0D);
    repeat (100) @(posedge clk);
    checkOutput("hold_no_strobes", strobe_count - s0, 0);
    checkOutput("hold_busy", busy, 1);
    #1 tx_full = 1'b0;
    wait_idle();

    // Byte received during FLUSH is dropped with a single overflow pulse
    tx_full = 1'b1;
    applyStimulus(8'h6A);
    applyStimulus(8'h6B);
    applyStimulus(8'h0D);
    repeat (3) @(posedge clk);
    applyStimulus(8'h41, 1);
    @(negedge clk);
    checkOutput("ovf_high", overflow, 1);
    @(negedge clk);
    checkOutput("ovf_low", overflow, 0);
    #1 tx_full = 1'b0;
    wait_idle();

    // Reset after the 2nd of 4 output bytes
    s0 = strobe_count;
    applyStimulus(8'h70);
    applyStimulus(8'h71);
    applyStimulus(8'h0D);
    n = 0;
    while (strobe_count < s0 + 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500)
      checkOutput("reset_wait_timeout", 0, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.delete();
    line_len = 0;
    @(negedge clk);
    checkOutput("mid_rst_tx_data", tx_data, 0);
    checkOutput("mid_rst_tx_strobe", tx_strobe, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_overflow", overflow, 0);
    s0 = strobe_count;
    repeat (20) @(posedge clk);
    checkOutput("post_rst_quiet", strobe_count - s0, 0);
    applyStimulus(8'h78);
    applyStimulus(8'h0D);
    wait_idle();
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
